bp_coh_wormhole_tx: RTL

Source endpoint for one coherence network (req, cmd or resp) of the accelerator mesh. It accepts a whole pre-formatted packet in parallel and serialises it, one flit per cycle, onto a ready-and wormhole link facing a mesh router's inbound port. It is the transmit counterpart of the link-level receivers the mesh routers present to tiles: it produces wormhole flit streams rather than consuming them.

---
 rtl/bp_coh_wormhole_tx.sv | 96 +++++++++
 1 files changed

// File: rtl/bp_coh_wormhole_tx.sv
//==============================================================================
// Module   : bp_coh_wormhole_tx
// Brief    : Serialises a parallel coherence packet onto a ready-and wormhole link.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bp_coh_wormhole_tx #(
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 8,
    parameter int len_width_p  = 4,
    parameter int max_flits_p  = 4
) (
    input  logic                                clk_i,
    input  logic                                async_reset_n_i,
    input  logic [max_flits_p*flit_width_p-1:0] pkt_i,
    input  logic                                pkt_v_i,
    output logic                                pkt_ready_and_o,
    output logic [flit_width_p-1:0]             link_data_o,
    output logic                                link_v_o,
    input  logic                                link_ready_and_i,
    output logic                                busy_o,
    output logic                                len_err_o
);

    localparam int c_cnt_w = (max_flits_p > 1) ? $clog2(max_flits_p) : 1;
    localparam logic [c_cnt_w-1:0] c_max_len = c_cnt_w'(max_flits_p - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                                   r_state;
    state_t                                   w_state_nxt;
    logic [max_flits_p-1:0][flit_width_p-1:0] r_pkt;
    logic [c_cnt_w-1:0]                       r_len;
    logic [c_cnt_w-1:0]                       r_cnt;
    logic                                     r_len_err;
    logic [len_width_p-1:0]                   w_head_len;
    logic [c_cnt_w-1:0]                       w_head_len_clamped;
    logic                                     w_over;
    logic                                     w_last;
    logic                                     w_link_hs;
    logic                                     w_accept;

    assign w_head_len         = pkt_i[cord_width_p +: len_width_p];
    assign w_over             = 32'(w_head_len) > 32'(max_flits_p - 1);
    assign w_head_len_clamped = w_over ? c_max_len : c_cnt_w'(w_head_len);

    assign w_last      = (r_cnt == r_len);
    assign link_v_o    = (r_state == ST_SEND);
    assign link_data_o = r_pkt[r_cnt];
    assign w_link_hs   = link_v_o & link_ready_and_i;
    // A new packet may load in the same cycle the last flit leaves, so the
    // link never sees a bubble between packets.
    assign pkt_ready_and_o = (r_state == ST_IDLE) | (w_link_hs & w_last);
    assign w_accept        = pkt_v_i & pkt_ready_and_o;
    assign busy_o          = link_v_o;
    assign len_err_o       = r_len_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_SEND;
            ST_SEND: if (w_link_hs && w_last) w_state_nxt = w_accept ? ST_SEND : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_len <= w_head_len_clamped;
                r_cnt <= '0;
                if (w_over) r_len_err <= 1'b1;
            end else if (w_link_hs && !w_last) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    // Payload storage needs no reset: it is only observed while link_v_o is high.
    always_ff @(posedge clk_i) begin
        if (w_accept) r_pkt <= pkt_i;
    end

endmodule

`default_nettype wire
